counter_run_ctrl: RTL and testbench

- Run/pause/step sequencer for a small binary up-counter, in the style of the team's 4-bit counter.
- Holds the count register and a programmable prescaler.
- Accepts single-cycle command pulses (start, stop, step, clear) and enforces a terminal-count rule, either one-shot or auto-reload.
- Produces the count plus status and event pulses for display or downstream logic.

---
 rtl/counter_run_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_run_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_ctrl.sv
// Run/pause/step sequencer around a WIDTH-bit up-counter with a DIV_W-bit prescaler.
// Commands are single-cycle pulses; terminal count is either one-shot or auto-reload.
module counter_run_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             clear,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] term,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             running,
  output logic             tick,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic             tick_d, done_d;
  logic             adv;
  logic             at_term;

  // Count value after one advance; a terminal hit either reloads to zero or holds.
  function automatic logic [WIDTH-1:0] advance_count(
    input logic [WIDTH-1:0] cur,
    input logic             hit,
    input logic             reload
  );
    if (!hit)
      advance_count = cur + 1'b1;
    else if (reload)
      advance_count = '0;
    else
      advance_count = cur;
  endfunction

  assign at_term = (count_q == term);

  // Command decode and prescaler: decides whether this edge advances the count.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    adv     = 1'b0;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      pre_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (!stop) begin
            if (start)
              state_d = S_RUN;
            else if (step)
              adv = 1'b1;
          end
        end
        S_RUN: begin
          if (stop)
            state_d = S_PAUSE;
          else if (pre_q == div) begin
            pre_d = '0;
            adv   = 1'b1;
          end else
            pre_d = pre_q + 1'b1;
        end
        S_DONE: begin
          if (!stop && start) begin
            state_d = S_RUN;
            pre_d   = '0;
            count_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Advance path shared by step and the prescaler; one-shot terminal parks in DONE.
      if (adv) begin
        tick_d  = 1'b1;
        done_d  = at_term;
        count_d = advance_count(count_q, at_term, auto_reload);
        if (at_term && !auto_reload)
          state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pre_q   <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      tick    <= tick_d;
      done    <= done_d;
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Bench for counter_run_ctrl: per-cycle comparison against a rule-level model,
// plus directed sequences with hand-computed expectations.
module tb_counter_run_ctrl;
  localparam int WIDTH = 4;
  localparam int DIV_W = 8;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0, stop = 1'b0, step = 1'b0, clear = 1'b0;
  logic             auto_reload = 1'b0;
  logic [WIDTH-1:0] term = '0;
  logic [DIV_W-1:0] div = '0;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             running, tick, done;

  int checks = 0;
  int errors = 0;

  counter_run_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .clear(clear),
    .auto_reload(auto_reload), .term(term), .div(div),
    .count(count), .state(state), .running(running), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int count;
    int pre;
    int st;
    bit tick;
    bit done;
  } mstate_t;

  mstate_t m = '{0, 0, IDLE, 1'b0, 1'b0};

  // Model: applies the command/prescaler/terminal rules with plain integer arithmetic.
  function automatic mstate_t model_next(mstate_t cur);
    mstate_t n;
    bit adv;
    n = cur;
    n.tick = 1'b0;
    n.done = 1'b0;
    adv = 1'b0;
    if (clear) begin
      n.count = 0; n.pre = 0; n.st = IDLE;
    end else if (stop) begin
      if (n.st == RUN) n.st = PAUSE;
    end else if (start && n.st != RUN) begin
      if (n.st == DONE) begin n.count = 0; n.pre = 0; end
      n.st = RUN;
    end else if (step && (n.st == IDLE || n.st == PAUSE)) begin
      adv = 1'b1;
    end else if (n.st == RUN) begin
      if (n.pre == int'(div)) begin n.pre = 0; adv = 1'b1; end
      else n.pre = (n.pre + 1) % (1 << DIV_W);
    end
    if (adv) begin
      n.tick = 1'b1;
      if (n.count != int'(term)) n.count = (n.count + 1) % (1 << WIDTH);
      else begin
        n.done = 1'b1;
        if (auto_reload) n.count = 0;
        else n.st = DONE;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{0, 0, IDLE, 1'b0, 1'b0};
    else     m <= model_next(m);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model.count", 32'(count), m.count);
    chk("model.state", 32'(state), m.st);
    chk("model.running", 32'(running), 32'(m.st == RUN));
    chk("model.tick", 32'(tick), 32'(m.tick));
    chk("model.done", 32'(done), 32'(m.done));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start; start = 1'b1; cyc(1); start = 1'b0; endtask
  task automatic do_stop;  stop  = 1'b1; cyc(1); stop  = 1'b0; endtask
  task automatic do_step;  step  = 1'b1; cyc(1); step  = 1'b0; endtask
  task automatic do_clear; clear = 1'b1; cyc(1); clear = 1'b0; endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    #12;
    chk("reset.count", 32'(count), 0);
    chk("reset.state", 32'(state), IDLE);
    chk("reset.tick", 32'(tick), 0);
    chk("reset.done", 32'(done), 0);
    rst = 1'b0;
    cyc(1);

    // One-shot, div=0, term=3
    div = 0; term = 3; auto_reload = 0;
    do_start;
    chk("t1.enter_run", 32'(state), RUN);
    chk("t1.count0", 32'(count), 0);
    cyc(1); chk("t1.count1", 32'(count), 1); chk("t1.tick1", 32'(tick), 1);
    cyc(1); chk("t1.count2", 32'(count), 2);
    cyc(1); chk("t1.count3", 32'(count), 3); chk("t1.nodone3", 32'(done), 0);
    cyc(1); chk("t1.hold3", 32'(count), 3); chk("t1.done", 32'(done), 1);
    chk("t1.tick_hold", 32'(tick), 1); chk("t1.state_done", 32'(state), DONE);
    chk("t1.running", 32'(running), 0);
    cyc(1); chk("t1.done_once", 32'(done), 0); chk("t1.frozen", 32'(count), 3);

    // Auto-reload, div=2, term=15
    div = 2; term = 15; auto_reload = 1;
    do_clear;
    do_start;
    cyc(3); chk("t2.first_adv", 32'(count), 1); chk("t2.tick", 32'(tick), 1);
    cyc(42); chk("t2.count15", 32'(count), 15);
    cyc(2); chk("t2.no_tick", 32'(tick), 0);
    cyc(1); chk("t2.wrap", 32'(count), 0); chk("t2.wrap_tick", 32'(tick), 1);
    chk("t2.wrap_done", 32'(done), 1); chk("t2.still_run", 32'(state), RUN);

    // Pause with prescaler held, div=3
    do_clear;
    div = 3; term = 15; auto_reload = 0;
    do_start;
    cyc(21);
    do_stop;
    chk("t3.paused", 32'(state), PAUSE); chk("t3.count5", 32'(count), 5);
    cyc(10); chk("t3.held", 32'(count), 5); chk("t3.still_pause", 32'(state), PAUSE);
    do_start;
    chk("t3.resume", 32'(state), RUN);
    cyc(2); chk("t3.not_yet", 32'(count), 5);
    cyc(1); chk("t3.adv6", 32'(count), 6); chk("t3.tick6", 32'(tick), 1);

    // Step from PAUSE into terminal, then step ignored in RUN
    do_clear;
    div = 0; term = 3; auto_reload = 0;
    do_start;
    cyc(2); chk("t4.count2", 32'(count), 2);
    do_stop; chk("t4.pause", 32'(state), PAUSE); chk("t4.pause_cnt", 32'(count), 2);
    do_step; chk("t4.step3", 32'(count), 3); chk("t4.step_tick", 32'(tick), 1);
    chk("t4.step_nodone", 32'(done), 0); chk("t4.step_state", 32'(state), PAUSE);
    do_step; chk("t4.hold3", 32'(count), 3); chk("t4.step_done", 32'(done), 1);
    chk("t4.hold_tick", 32'(tick), 1); chk("t4.to_done", 32'(state), DONE);
    div = 7;
    do_start; chk("t4.restart", 32'(count), 0); chk("t4.restart_run", 32'(state), RUN);
    do_step; chk("t4.run_step_cnt", 32'(count), 0); chk("t4.run_step_tick", 32'(tick), 0);

    // clear beats start in RUN
    do_clear;
    div = 0; term = 15; auto_reload = 0;
    do_start;
    cyc(9); chk("t5.count9", 32'(count), 9);
    clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
    chk("t5.idle", 32'(state), IDLE); chk("t5.zero", 32'(count), 0);
    chk("t5.no_tick", 32'(tick), 0); chk("t5.no_done", 32'(done), 0);

    // Asynchronous reset mid-cycle
    do_start;
    cyc(7); chk("t6.count7", 32'(count), 7); chk("t6.tick7", 32'(tick), 1);
    #3 rst = 1'b1;
    #1;
    chk("t6.rst_count", 32'(count), 0); chk("t6.rst_state", 32'(state), IDLE);
    chk("t6.rst_tick", 32'(tick), 0); chk("t6.rst_done", 32'(done), 0);
    chk("t6.rst_running", 32'(running), 0);
    #1 rst = 1'b0;
    cyc(3); chk("t6.idle_cnt", 32'(count), 0); chk("t6.idle_state", 32'(state), IDLE);

    // term lowered below count during RUN: wrap then terminate
    div = 0; term = 15; auto_reload = 0;
    do_start;
    cyc(10); chk("t7.count10", 32'(count), 10);
    term = 4;
    cyc(10); chk("t7.reach4", 32'(count), 4); chk("t7.run", 32'(state), RUN);
    cyc(1); chk("t7.hold4", 32'(count), 4); chk("t7.done", 32'(done), 1);
    chk("t7.state_done", 32'(state), DONE);

    // div lowered below prescaler mid-run: prescaler wraps before matching
    do_clear;
    div = 10; term = 15; auto_reload = 0;
    do_start;
    cyc(6);
    div = 2;
    cyc(252); chk("t8.no_adv", 32'(count), 0); chk("t8.no_tick", 32'(tick), 0);
    cyc(1); chk("t8.adv", 32'(count), 1); chk("t8.tick", 32'(tick), 1);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
